led_ctrl: RTL
=============

LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 Parameter LED_W, default 24, number of LED outputs, legal range 1..32.
REQ-002 Parameter BASE_ADDR, default 12'h060, 12-bit address of the DATA register; other registers sit at fixed offsets from it.
REQ-003 Parameter BLINK_RST, default 32'd12_499_999, reset value of BLINK_HALF.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 io_en  input  1  write strobe; a write occurs on each rising edge where io_en=1.
REQ-007 io_addr  input  12  register address for both write and read.
REQ-008 io_write_data  input  32  write data.
REQ-009 io_read_data  output  32  combinational read-back of the register selected by io_addr.
REQ-010 device_led  output  LED_W  registered LED drive, 1 = lit.

Function
REQ-011 Register map SHALL be: DATA at BASE_ADDR, bits [LED_W-1:0]; MODE at BASE_ADDR+4, bit0 blink_en, bit1 pwm_en; BLINK_HALF at BASE_ADDR+8, 32 bits; DUTY at BASE_ADDR+12, bits [7:0].
REQ-012 Write: when io_en=1 and io_addr matches a register, that register SHALL take the low bits of io_write_data it defines; unused upper bits SHALL be discarded.
REQ-013 Writes to any unmapped address SHALL change no state.
REQ-014 io_read_data SHALL return the selected register zero-extended to 32 bits, and 0 for unmapped addresses; the value reflects register state before the current edge.
REQ-015 Blink counter bcnt (32 bit) SHALL increment each cycle; when bcnt >= BLINK_HALF it SHALL load 0 and phase SHALL toggle on the same edge.
REQ-016 BLINK_HALF=0 SHALL toggle phase on every cycle.
REQ-017 A write to BLINK_HALF SHALL, on the same edge, clear bcnt to 0 and set phase to 1; this overrides the wrap of REQ-015.
REQ-018 The blink counter SHALL run regardless of blink_en.
REQ-019 The PWM counter pcnt (8 bit) SHALL increment every cycle and wrap from 255 to 0.
REQ-020 pwm_on SHALL be 1 when DUTY=8'hFF, otherwise (pcnt < DUTY); DUTY=0 SHALL give pwm_on permanently 0.
REQ-021 Next device_led SHALL be DATA AND (blink_en ? all phase : all ones) AND (pwm_en ? all pwm_on : all ones), bitwise across LED_W.
REQ-022 device_led SHALL be registered, so a write to DATA or MODE is visible on device_led one edge after the write edge.
REQ-023 When io_en=1 targets DATA, device_led SHALL follow the new value only from the next edge, never combinationally.

Reset
REQ-024 On rst_n=0, asynchronously: DATA=0, MODE=0, BLINK_HALF=BLINK_RST, DUTY=8'hFF, bcnt=0, pcnt=0, phase=1, device_led=0.
REQ-025 Reset asserted mid-blink or mid-PWM period SHALL abandon the period; counting SHALL restart from 0 on the first edge after release.
REQ-026 io_read_data SHALL show the reset values during and after reset.

Verification
REQ-027 Reset then write DATA=32'hFFAA_5501 (LED_W=24) -> read DATA = 32'h00AA_5501; device_led = 24'hAA5501 one edge after the write edge.
REQ-028 MODE=1, BLINK_HALF=3, DATA=24'h00000F -> device_led alternates 24'h00000F / 24'h000000, 4 cycles each, first high phase starting right after the BLINK_HALF write.
REQ-029 MODE=2, DUTY=64, DATA=24'hFFFFFF -> over any 256 consecutive cycles device_led is all-ones for exactly 64 cycles; DUTY=0 -> never lit; DUTY=255 -> always lit.
REQ-030 Write to address BASE_ADDR+16 with data 32'hFFFF_FFFF -> no register or device_led change, read of that address returns 0.
REQ-031 MODE=3, BLINK_HALF=0, DUTY=128 -> device_led equals DATA only on cycles where phase=1 and pcnt<128; all other cycles it is 0.
REQ-032 Assert rst_n=0 mid-blink with MODE=1 -> device_led=0 immediately without a clock edge; all registers at reset values; after release, phase=1 and bcnt counts from 0.

Source files
------------

// File: rtl/led_ctrl.sv
// LED controller: memory-mapped DATA/MODE/BLINK_HALF/DUTY registers driving a
// registered LED bank, with optional blink gating and 8-bit PWM dimming.
module led_ctrl #(
   parameter int          LED_W     = 24,
   parameter logic [11:0] BASE_ADDR = 12'h060,
   parameter logic [31:0] BLINK_RST = 32'd12_499_999
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             io_en,
   input  logic [11:0]      io_addr,
   input  logic [31:0]      io_write_data,
   output logic [31:0]      io_read_data,
   output logic [LED_W-1:0] device_led
);

   localparam logic [11:0] A_DATA  = BASE_ADDR;
   localparam logic [11:0] A_MODE  = BASE_ADDR + 12'd4;
   localparam logic [11:0] A_HALF  = BASE_ADDR + 12'd8;
   localparam logic [11:0] A_DUTY  = BASE_ADDR + 12'd12;

   logic [LED_W-1:0] data;
   logic [1:0]       mode;        // bit0 blink_en, bit1 pwm_en
   logic [31:0]      blink_half;
   logic [7:0]       duty;
   logic [31:0]      bcnt;
   logic [7:0]       pcnt;
   logic             phase;
   logic             pwm_on;
   logic [LED_W-1:0] led_next;
   logic [31:0]      data_ext;

   logic wr_data, wr_mode, wr_half, wr_duty;
   assign wr_data = io_en && (io_addr == A_DATA);
   assign wr_mode = io_en && (io_addr == A_MODE);
   assign wr_half = io_en && (io_addr == A_HALF);
   assign wr_duty = io_en && (io_addr == A_DUTY);

   // Configuration registers; unmapped writes fall through and change nothing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
         mode <= 2'b00;
         duty <= 8'hFF;
      end else begin
         if (wr_data) data <= io_write_data[LED_W-1:0];
         if (wr_mode) mode <= io_write_data[1:0];
         if (wr_duty) duty <= io_write_data[7:0];
      end
   end

   // Blink timebase: a BLINK_HALF write restarts the half-period in the lit phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_half <= BLINK_RST;
         bcnt       <= '0;
         phase      <= 1'b1;
      end else if (wr_half) begin
         blink_half <= io_write_data;
         bcnt       <= '0;
         phase      <= 1'b1;
      end else if (bcnt >= blink_half) begin
         bcnt       <= '0;
         phase      <= ~phase;
      end else begin
         bcnt       <= bcnt + 32'd1;
      end
   end

   // Free-running PWM counter, wraps naturally at 8 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pcnt <= '0;
      else        pcnt <= pcnt + 8'd1;
   end

   // DUTY=FF is forced fully on since pcnt<255 alone would leave one dark cycle.
   always_comb begin
      pwm_on   = (duty == 8'hFF) || (pcnt < duty);
      led_next = data
               & ({LED_W{phase}}  | {LED_W{~mode[0]}})
               & ({LED_W{pwm_on}} | {LED_W{~mode[1]}});
   end

   // LED outputs are registered so register writes appear one edge later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) device_led <= '0;
      else        device_led <= led_next;
   end

   // Combinational read-back of pre-edge register state.
   always_comb begin
      data_ext              = '0;
      data_ext[LED_W-1:0]   = data;
      io_read_data          = '0;
      case (io_addr)
         A_DATA:  io_read_data = data_ext;
         A_MODE:  io_read_data = {30'd0, mode};
         A_HALF:  io_read_data = blink_half;
         A_DUTY:  io_read_data = {24'd0, duty};
         default: io_read_data = '0;
      endcase
   end

endmodule
